// File: rtl/masked_pkg.sv
// Shared types and constants for the masked share generator.
package masked_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRAW_P,
    DRAW_H,
    LAUNCH,
    WAIT
  } state_e;

  // x^32 + x^22 + x^2 + x + 1, Galois form, shifting right
  localparam logic [31:0] LFSR_TAPS    = 32'h80200003;
  localparam logic [31:0] SEED_DEFAULT = 32'h1a465464;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
  endfunction

endpackage

// File: rtl/masked_share_gen_if.sv
// Bus between the share generator and masked_arith: shares, pass-through operands, start/done.
interface masked_share_gen_if #(
  parameter int unsigned RADIX = 13
);
  logic             arith_start;
  logic             arith_done;
  logic [RADIX-1:0] P1;
  logic [RADIX-1:0] P2;
  logic [RADIX-1:0] H1;
  logic [RADIX-1:0] H2;
  logic [RADIX-1:0] R;
  logic [RADIX-1:0] kInv;

  modport master (
    output arith_start, P1, P2, H1, H2, R, kInv,
    input  arith_done
  );

  modport slave (
    input  arith_start, P1, P2, H1, H2, R, kInv,
    output arith_done
  );
endinterface

// File: rtl/share_lfsr.sv
// 32-bit Galois mask LFSR; a zero load value is replaced by the seed so the state never reaches 0.
module share_lfsr #(
  parameter logic [31:0] SEED = masked_pkg::SEED_DEFAULT
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        step,
  output logic [31:0] state
);
  import masked_pkg::*;

  logic [31:0] state_q;

  // Load has priority over step; hold otherwise.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= SEED;
    end else if (load) begin
      state_q <= (load_val == '0) ? SEED : load_val;
    end else if (step) begin
      state_q <= lfsr_next(state_q);
    end
  end

  assign state = state_q;

endmodule

// File: rtl/masked_share_gen.sv
// Splits key and hash into additive shares with fresh LFSR masks and sequences one masked_arith run.
module masked_share_gen #(
  parameter int unsigned RADIX        = 13,
  parameter logic [31:0] SEED_DEFAULT = masked_pkg::SEED_DEFAULT,
  parameter logic [15:0] TIMEOUT      = 16'd4095
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 start_in,
  input  logic [RADIX-1:0]     priv_key,
  input  logic [RADIX-1:0]     msg_hash,
  input  logic [RADIX-1:0]     r_in,
  input  logic [RADIX-1:0]     kinv_in,
  input  logic                 reseed,
  input  logic [31:0]          seed_in,
  output logic                 busy,
  output logic                 done_out,
  output logic                 timeout_err,
  masked_share_gen_if.master   arith
);
  import masked_pkg::*;

  state_e           state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [RADIX-1:0] key_q, hash_q, r_q, kinv_q;
  logic [RADIX-1:0] p1_q, p2_q, h1_q, h2_q, rout_q, kout_q;
  logic             done_q, terr_q;
  logic [31:0]      lfsr_state;
  logic [RADIX-1:0] mask;
  logic             lfsr_load, lfsr_step, accept, timeout_hit, finish;

  // Reseed applies in IDLE even alongside start_in, so DRAW_P already steps the new seed.
  assign lfsr_load = (state_q == IDLE) && reseed;
  assign lfsr_step = (state_q == DRAW_P) || (state_q == DRAW_H);
  // Mask is the post-step value, i.e. the same value the LFSR register takes at this edge.
  assign mask      = RADIX'(lfsr_next(lfsr_state));

  share_lfsr #(
    .SEED (SEED_DEFAULT)
  ) u_lfsr (
    .clock    (clock),
    .resetn   (resetn),
    .load     (lfsr_load),
    .load_val (seed_in),
    .step     (lfsr_step),
    .state    (lfsr_state)
  );

  // State and wait counter registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, counter and strobe decode; done wins over a simultaneous timeout.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    accept      = 1'b0;
    timeout_hit = 1'b0;
    finish      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_in) begin
          accept  = 1'b1;
          state_d = DRAW_P;
        end
      end
      DRAW_P: state_d = DRAW_H;
      DRAW_H: state_d = LAUNCH;
      LAUNCH: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d       = cnt_q + 16'd1;
        timeout_hit = !arith.arith_done && (cnt_d == TIMEOUT);
        if (arith.arith_done || timeout_hit) begin
          finish  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, share computation and completion flags.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      key_q  <= '0;
      hash_q <= '0;
      r_q    <= '0;
      kinv_q <= '0;
      p1_q   <= '0;
      p2_q   <= '0;
      h1_q   <= '0;
      h2_q   <= '0;
      rout_q <= '0;
      kout_q <= '0;
      done_q <= 1'b0;
      terr_q <= 1'b0;
    end else begin
      done_q <= (state_q == WAIT) && arith.arith_done;
      if (accept) begin
        key_q  <= priv_key;
        hash_q <= msg_hash;
        r_q    <= r_in;
        kinv_q <= kinv_in;
        terr_q <= 1'b0;
      end
      if (state_q == DRAW_P) begin
        p1_q <= mask;
        p2_q <= key_q - mask;
      end
      if (state_q == DRAW_H) begin
        h1_q   <= mask;
        h2_q   <= hash_q - mask;
        rout_q <= r_q;
        kout_q <= kinv_q;
      end
      if (timeout_hit) begin
        terr_q <= 1'b1;
      end
      if (finish) begin
        p1_q   <= '0;
        p2_q   <= '0;
        h1_q   <= '0;
        h2_q   <= '0;
        rout_q <= '0;
        kout_q <= '0;
      end
    end
  end

  assign busy              = (state_q != IDLE);
  assign done_out          = done_q;
  assign timeout_err       = terr_q;
  assign arith.arith_start = (state_q == LAUNCH);
  assign arith.P1          = p1_q;
  assign arith.P2          = p2_q;
  assign arith.H1          = h1_q;
  assign arith.H2          = h2_q;
  assign arith.R           = rout_q;
  assign arith.kInv        = kout_q;

endmodule
